rv_fetch_queue: RTL
===================

Name: rv_fetch_queue

Overview:
- Parametrised instruction-fetch front end; generational successor to the single-cycle IF stage.
- Decouples the core from a variable-latency instruction memory via a valid/ready request channel and an in-order response channel.
- Buffers up to DEPTH fetched instructions, each tagged with its PC, and presents them to decode through a valid/ready handshake.
- Supports branch/jump redirect with queue flush and discard of in-flight responses.

Parameters:
XLEN, 32, address/instruction width
DEPTH, 4, instruction queue entries; power of 2, >= 2; also caps in-flight + buffered instructions
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  XLEN  fetch address (word aligned)
imem_rsp_valid  input  1  response valid; exactly one per accepted request, in order, latency >= 1 cycle
imem_rsp_data  input  XLEN  instruction word
inst_valid  output  1  queue head valid
inst_ready  input  1  decode consumes head
inst_data  output  XLEN  head instruction
inst_pc  output  XLEN  head PC
redirect_valid  input  1  branch/jump taken; flush
redirect_pc  input  XLEN  new fetch target; bits [1:0] ignored and forced to 0
occupancy  output  $clog2(DEPTH+1)  valid entries in queue

Behaviour:
- Reset (async assert, sync release): fetch_pc=RESET_PC, rsp_pc=RESET_PC, queue empty, inflight=0, discard=0. Outputs: imem_req_valid=0, inst_valid=0, occupancy=0, imem_req_addr=RESET_PC, inst_data/inst_pc=0.
- Credit: imem_req_valid = !redirect_valid && (occupancy + inflight < DEPTH). imem_req_addr = fetch_pc. Never drop valid without a handshake unless a redirect occurs.
- Request accepted (valid && ready): fetch_pc += 4, modulo 2^XLEN (wrap 0xFFFF_FFFC -> 0); inflight++.
- Response:
  - If discard > 0: drop the response, decrement discard and inflight.
  - Otherwise: push {imem_rsp_data, rsp_pc}, rsp_pc += 4, inflight--.
  - Credit guarantees no push when full. An unexpected response with inflight=0 is ignored.
- Queue is a registered circular FIFO with no bypass. A response at cycle N gives inst_valid at N+1 at the earliest.
- Pop on inst_valid && inst_ready. Simultaneous push and pop leaves occupancy unchanged. Pointers wrap modulo DEPTH.
- Redirect cycle:
  - No request is issued.
  - Any response arriving this cycle is dropped.
  - No pop occurs; inst_ready is ignored.
- Next cycle after redirect:
  - Queue empty; fetch_pc = rsp_pc = {redirect_pc[XLEN-1:2], 2'b00}.
  - discard = inflight after this cycle's accounting (all still-outstanding responses are stale).
  - inflight keeps counting stale requests until they drain.
  - Requests resume in this same cycle if credit allows.
- Back-to-back redirects: the last one wins, and discard accumulates correctly.
- Counters are $clog2(DEPTH+1) bits wide. inflight <= DEPTH always.
- Reset mid-operation: all state returns to reset values immediately. Any in-flight memory responses arriving after reset release are protocol violations (memory is reset alongside).

Test Plan:
- Reset then imem_req_ready=1, 1-cycle response latency, inst_ready=1 -> addresses 0x0,0x4,0x8,... issued each cycle; inst_pc follows the same sequence with inst_data matching memory; first inst_valid 2 cycles after first request accept.
- inst_ready=0, DEPTH=4, ready memory -> exactly 4 requests accepted; occupancy reaches 4; imem_req_valid held 0; one pop re-enables one request.
- 3-cycle response latency with 3 requests in flight, redirect_pc=0x100 -> 3 stale responses dropped; first queued instruction has inst_pc=0x100; next request addr 0x100.
- Redirect in the same cycle as a response and a pop attempt -> response dropped, occupancy 0 next cycle, no request issued in the redirect cycle.
- RESET_PC=32'hFFFF_FFF8 -> fetch addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; redirect_pc=0x203 -> fetch address 0x200.
- Assert rst mid-stream with occupancy 3 -> occupancy 0, inst_valid 0, imem_req_valid 0 asynchronously; fetch restarts at RESET_PC after release.

Source files
------------

// File: rtl/rv_fetch_if.sv
// rtl/rv_fetch_if.sv - fetch front-end bundle: imem request/response, decode handshake, redirect
interface rv_fetch_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst_data;
    logic [XLEN-1:0] inst_pc;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic [CW-1:0]   occupancy;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, occupancy,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, occupancy,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/rv_fetch_queue.sv
// rtl/rv_fetch_queue.sv - credit-limited instruction fetch queue with redirect flush
module rv_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic         clk,
    input logic         rst,
    rv_fetch_if.master  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [CW-1:0]   count;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   discard;
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [XLEN-1:0] q_data [DEPTH];
    logic [XLEN-1:0] q_pc   [DEPTH];

    logic            credit;
    logic            req_fire;
    logic            rsp_live;
    logic            push;
    logic            pop;
    logic [CW-1:0]   inflight_nxt;
    logic [XLEN-1:0] target_pc;

    // Stale requests still count against credit until their responses drain.
    assign credit    = ({1'b0, count} + {1'b0, inflight}) < (CW+1)'(DEPTH);
    assign req_fire  = bus.imem_req_valid && bus.imem_req_ready;
    assign rsp_live  = bus.imem_rsp_valid && (inflight != '0);
    assign push      = rsp_live && (discard == '0) && !bus.redirect_valid;
    assign pop       = (count != '0) && bus.inst_ready && !bus.redirect_valid;
    assign target_pc = bus.redirect_pc & ~XLEN'(3);

    assign inflight_nxt = inflight + CW'(req_fire) - CW'(rsp_live);

    assign bus.imem_req_valid = !rst && !bus.redirect_valid && credit;
    assign bus.imem_req_addr  = fetch_pc;
    assign bus.inst_valid     = (count != '0);
    assign bus.inst_data      = bus.inst_valid ? q_data[rptr] : '0;
    assign bus.inst_pc        = bus.inst_valid ? q_pc[rptr]   : '0;
    assign bus.occupancy      = count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            count    <= '0;
            inflight <= '0;
            discard  <= '0;
            wptr     <= '0;
            rptr     <= '0;
        end else begin
            inflight <= inflight_nxt;
            if (bus.redirect_valid) begin
                // Everything still outstanding after this cycle belongs to the old path.
                fetch_pc <= target_pc;
                rsp_pc   <= target_pc;
                count    <= '0;
                wptr     <= '0;
                rptr     <= '0;
                discard  <= inflight_nxt;
            end else begin
                if (req_fire)
                    fetch_pc <= fetch_pc + XLEN'(4);
                if (rsp_live && (discard != '0))
                    discard <= discard - CW'(1);
                if (push) begin
                    wptr   <= wptr + AW'(1);
                    rsp_pc <= rsp_pc + XLEN'(4);
                end
                if (pop)
                    rptr <= rptr + AW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_data[wptr] <= bus.imem_rsp_data;
            q_pc[wptr]   <= rsp_pc;
        end
    end
endmodule
